// File: rtl/blink_sched.sv
// blink_sched: shares one registered Blink-64 core between two requesters.
// Owns the round-key register and the core input registers, follows each
// issued op through a LAT+1 stage tag pipeline, and hands results back in
// issue order through a small response FIFO. Issue is credit-guarded, so a
// result always has a FIFO slot waiting for it.
//
// Handshakes (all valid/ready, transfer on the rising edge where both are 1):
//   rqN_valid/rqN_ready : an op moves when rqN_valid && rqN_ready. Ready is
//                         combinational and may depend on valid. At most one
//                         requester sees ready in a cycle.
//   rsp_valid/rsp_ready : the head entry leaves on rsp_valid && rsp_ready.
//                         rsp_valid never depends on rsp_ready.
//   key_wr/key_wr_ready : key_in is captured on key_wr && key_wr_ready.
//                         Holding key_wr blocks new grants, so the pipeline
//                         and FIFO drain and key_wr_ready eventually rises.
module blink_sched #(
  parameter int N      = 64,   // block width
  parameter int TW     = 64,   // tweak width
  parameter int KW     = 448,  // round-key width
  parameter int LAT    = 2,    // core latency in cycles, >= 1
  parameter int FDEPTH = 4     // response FIFO depth, power of 2, >= 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr,
  input  logic [KW-1:0] key_in,
  output logic          key_wr_ready,
  input  logic          rq0_valid,
  output logic          rq0_ready,
  input  logic          rq0_enc,
  input  logic [N-1:0]  rq0_pt,
  input  logic [TW-1:0] rq0_tw,
  input  logic          rq1_valid,
  output logic          rq1_ready,
  input  logic          rq1_enc,
  input  logic [N-1:0]  rq1_pt,
  input  logic [TW-1:0] rq1_tw,
  output logic          core_enc,
  output logic [KW-1:0] core_K0,
  output logic [N-1:0]  core_P,
  output logic [TW-1:0] core_T,
  input  logic [N-1:0]  core_C,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_id,
  output logic          busy
);

  localparam int PW = $clog2(FDEPTH);              // FIFO pointer width
  localparam int CW = PW + 1;                      // FIFO occupancy width
  localparam int IW = $clog2(LAT + 2);             // in-flight count width
  localparam int SW = ((IW > CW) ? IW : CW) + 1;   // credit sum width
  localparam logic [CW-1:0] DEPTH_C = CW'(FDEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(FDEPTH);

  // Key state
  logic          key_valid;
  logic          key_accept;

  // Arbitration
  logic          rr;          // requester that wins when both are valid
  logic          credit;
  logic          eligible;
  logic          grant;
  logic          grant_id;

  // Tag pipeline: stage i holds the op issued i+1 edges ago
  logic [LAT:0]  tag_v;
  logic [LAT:0]  tag_id;
  logic [IW-1:0] inflight;

  // Response FIFO
  logic [N-1:0]  fifo_data [FDEPTH];
  logic          fifo_id   [FDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Count the live tags; every one of them owns a future FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) begin
      inflight = inflight + IW'(tag_v[i]);
    end
  end

  // An op may only issue while ops in the core plus queued results leave a slot free.
  assign credit = (SW'(inflight) + SW'(fifo_count)) < DEPTH_S;

  // Round-robin grant: a lone valid requester may win every cycle.
  always_comb begin
    eligible  = key_valid && !key_wr && credit;
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    if (eligible) begin
      rq0_ready = rq0_valid && (!rq1_valid || (rr == 1'b0));
      rq1_ready = rq1_valid && (!rq0_valid || (rr == 1'b1));
    end
    grant    = rq0_ready || rq1_ready;
    grant_id = rq1_ready;
  end

  // Status: a key may only be replaced once nothing depends on the old one.
  assign fifo_empty   = (fifo_count == '0);
  assign busy         = (|tag_v) || !fifo_empty;
  assign key_wr_ready = !busy && rst;
  assign key_accept   = key_wr && key_wr_ready;

  // Key register; a write lands only when the scheduler is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      core_K0   <= '0;
    end else if (key_accept) begin
      key_valid <= 1'b1;
      core_K0   <= key_in;
    end
  end

  // Core input registers and round-robin pointer, loaded on each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_enc <= 1'b0;
      core_P   <= '0;
      core_T   <= '0;
      rr       <= 1'b0;
    end else if (grant) begin
      core_enc <= grant_id ? rq1_enc : rq0_enc;
      core_P   <= grant_id ? rq1_pt  : rq0_pt;
      core_T   <= grant_id ? rq1_tw  : rq0_tw;
      rr       <= ~grant_id;
    end
  end

  // Tag pipeline: a tag reaches stage LAT in the cycle core_C holds its result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LAT-1:0], grant};
      tag_id <= {tag_id[LAT-1:0], grant_id};
    end
  end

  assign push = tag_v[LAT];
  assign pop  = rsp_valid && rsp_ready;

  // FIFO storage, cleared on reset so the response outputs read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FDEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_id[i]   <= 1'b0;
      end
    end else if (push) begin
      fifo_data[wr_ptr] <= core_C;
      fifo_id[wr_ptr]   <= tag_id[LAT];
    end
  end

  // FIFO pointers wrap naturally; occupancy is unchanged on simultaneous push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_data[rd_ptr];
  assign rsp_id    = fifo_id[rd_ptr];

  // Credit guarantees a free slot for every push that is not matched by a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push && !pop) |-> (fifo_count != DEPTH_C));

  // The arbiter never grants both requesters at once.
  a_one_grant: assert property (@(posedge clk) disable iff (!rst)
    !(rq0_ready && rq1_ready));

endmodule
